// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute/memory/writeback
// with a sticky illegal-instruction trap and a 32-bit retired-instruction counter.
module rv32i_ctrl_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        imem_valid,
    input  logic        dmem_ready,
    input  logic        is_R,
    input  logic        is_I,
    input  logic        is_S,
    input  logic        is_B,
    input  logic        is_U,
    input  logic        is_J,
    input  logic        is_load,
    input  logic        is_jalr,
    input  logic        br_taken,
    output logic        imem_req,
    output logic        ir_load,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    localparam int unsigned StateW = 3;
    localparam int unsigned CntW   = 32;

    typedef enum logic [StateW-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   instret_q;
    logic              retire;

    // Strobes are decoded from the current state and the handshake inputs so
    // that fetch acceptance, branch retire and store retire land in the same cycle.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_load  = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 2'd0;
        rf_we    = 1'b0;
        wb_sel   = 2'd0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        illegal  = 1'b0;
        retire   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = $onehot({is_R, is_I, is_S, is_B, is_U, is_J}) ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (is_B) begin
                    pc_we  = 1'b1;
                    pc_src = br_taken ? 2'd1 : 2'd0;
                    retire = 1'b1;
                end else if (is_S || is_load) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_S;
                if (dmem_ready) begin
                    if (is_S) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                wb_sel = is_load ? 2'd1 : ((is_J || is_jalr) ? 2'd2 : 2'd0);
                pc_src = is_jalr ? 2'd2 : (is_J ? 2'd1 : 2'd0);
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
        // Run enable is only honoured at instruction boundaries
        if (retire) state_d = en ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + CntW'(1);
        end
    end

    assign state   = StateW'(state_q);
    assign instret = instret_q;

endmodule

// File: doc/rv32i_ctrl_fsm.md
RV32I_CTRL_FSM -- requirements
Module: rv32i_ctrl_fsm

Interface
REQ-001 Parameter: none; the block is fixed to RV32I, 32-bit retire counter.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  run enable, sampled in IDLE and at instruction retirement.
REQ-005 imem_valid  input  1  instruction memory has instruction for current PC.
REQ-006 dmem_ready  input  1  data memory access complete.
REQ-007 is_R, is_I, is_S, is_B, is_U, is_J  input  1 each  instruction-format flags from decoder; stable from DECODE to retirement.
REQ-008 is_load  input  1  I-format load; is_jalr  input  1  JALR; br_taken  input  1  branch compare result.
REQ-009 imem_req  output  1  instruction fetch request.
REQ-010 ir_load  output  1  instruction register load strobe.
REQ-011 pc_we  output  1  PC write enable; pc_src  output  2  0=PC+4, 1=PC+imm, 2=rs1+imm (JALR).
REQ-012 rf_we  output  1  register file write; wb_sel  output  2  0=ALU, 1=memory, 2=PC+4.
REQ-013 dmem_req  output  1  data access request; dmem_we  output  1  store (1) vs load (0).
REQ-014 illegal  output  1  sticky illegal-instruction flag.
REQ-015 state  output  3  current state code; instret  output  32  retired-instruction count.

Function
REQ-016 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; codes 7 SHALL go to TRAP.
REQ-017 IDLE: en=1 -> FETCH next cycle; else stay; all strobes 0.
REQ-018 FETCH: imem_req=1 every cycle; when imem_valid=1, ir_load=1 that cycle (combinational) and -> DECODE; otherwise wait indefinitely.
REQ-019 DECODE: exactly one of is_R/I/S/B/U/J set -> EXEC; zero or more than one set -> TRAP.
REQ-020 EXEC, is_B: retire this cycle; pc_we=1, pc_src=1 if br_taken else 0.
REQ-021 EXEC, is_S or is_load -> MEM; is_R, is_U, is_J, non-load is_I -> WB; no strobes asserted in EXEC except REQ-020.
REQ-022 MEM: dmem_req=1 and dmem_we=is_S held every cycle until dmem_ready=1; store retires in the dmem_ready cycle (pc_we=1, pc_src=0); load -> WB.
REQ-023 WB: one cycle; rf_we=1; wb_sel=1 for load, 2 for is_J or is_jalr, else 0; pc_we=1; pc_src=2 if is_jalr, 1 if is_J, else 0; retire.
REQ-024 Retire cycle: instret increments by 1 (wraps 0xFFFFFFFF -> 0); next state FETCH if en=1, else IDLE.
REQ-025 en deasserted mid-instruction SHALL NOT abort it; it is only checked at retirement.
REQ-026 TRAP: illegal=1, all other strobes 0, no exit except reset; instret frozen.
REQ-027 pc_we, rf_we, ir_load, dmem_req SHALL never be asserted outside the states listed above.
REQ-028 Latency: ALU/U/J = 4 cycles FETCH-to-retire with imem_valid immediate; branch = 3; load = 5 + memory wait; store = 4 + memory wait.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, instret=0, illegal=0, and every output strobe to 0, regardless of clock or current state.
REQ-030 Release of rst_n SHALL resume at IDLE; an access in flight (FETCH/MEM) is abandoned without retirement.

Verification
REQ-031 ADD (is_R=1), en=1, imem_valid=1 -> states 1,2,3,5; WB cycle rf_we=1, wb_sel=0, pc_we=1, pc_src=0; instret 0 -> 1.
REQ-032 BEQ with br_taken=1 then br_taken=0 -> retire in EXEC, pc_src=1 then 0, rf_we never 1; instret +2.
REQ-033 LW with dmem_ready low 3 cycles -> dmem_req=1, dmem_we=0 for 4 cycles, then WB with wb_sel=1; JALR -> wb_sel=2, pc_src=2.
REQ-034 Decode flags all 0 (or is_R=is_I=1) -> TRAP, illegal=1 held 20 cycles, imem_req=0, instret unchanged.
REQ-035 rst_n pulsed low mid-MEM -> same-cycle state=0, dmem_req=0, instret=0; en dropped during EXEC -> instruction retires, then IDLE.
REQ-036 instret preset by 0xFFFFFFFF retirements (force) plus one ADD -> instret=0.
